// File: rtl/rv32_decode_execute.sv
`default_nettype none
// rv32_decode_execute: combinational RV32I decode + ALU slice, with the reset-button debouncer.
// Rev 1.0

module rv32_decode_execute #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  output logic        btn_clean,
  input  logic [31:0] instruction,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [4:0]  alu_op,
  output logic [11:0] immediate,
  output logic [31:0] imm_j,
  output logic [2:0]  load_operation,
  output logic [2:0]  store_operation,
  output logic [4:0]  reg_read_address1,
  output logic [4:0]  reg_read_address2,
  output logic [4:0]  reg_write_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        reg_read_enable,
  output logic        reg_write_enable,
  output logic        jump,
  output logic        is_jal,
  output logic        is_jalr,
  output logic [31:0] alu_result,
  output logic        zero
);

  localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [6:0] C_OPC_R     = 7'b0110011;
  localparam logic [6:0] C_OPC_I     = 7'b0010011;
  localparam logic [6:0] C_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE = 7'b0100011;
  localparam logic [6:0] C_OPC_JAL   = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR  = 7'b1100111;

  localparam logic [4:0] C_ADD   = 5'd0;
  localparam logic [4:0] C_SUB   = 5'd1;
  localparam logic [4:0] C_SLL   = 5'd2;
  localparam logic [4:0] C_SLT   = 5'd3;
  localparam logic [4:0] C_SLTU  = 5'd4;
  localparam logic [4:0] C_XOR   = 5'd5;
  localparam logic [4:0] C_SRL   = 5'd6;
  localparam logic [4:0] C_SRA   = 5'd7;
  localparam logic [4:0] C_OR    = 5'd8;
  localparam logic [4:0] C_AND   = 5'd9;
  localparam logic [4:0] C_ADDI  = 5'd10;
  localparam logic [4:0] C_SLTI  = 5'd11;
  localparam logic [4:0] C_SLTIU = 5'd12;
  localparam logic [4:0] C_XORI  = 5'd13;
  localparam logic [4:0] C_ORI   = 5'd14;
  localparam logic [4:0] C_ANDI  = 5'd15;
  localparam logic [4:0] C_SLLI  = 5'd16;
  localparam logic [4:0] C_SRLI  = 5'd17;
  localparam logic [4:0] C_SRAI  = 5'd18;
  localparam logic [4:0] C_ADDR  = 5'd19;
  localparam logic [4:0] C_NOP   = 5'd31;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_alt;
  logic [4:0]  w_alu_op;
  logic [11:0] w_imm;
  logic [31:0] w_imm_sext;
  logic [31:0] w_res;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];
  assign w_alt    = instruction[30];

  assign reg_read_address1 = instruction[19:15];
  assign reg_read_address2 = instruction[24:20];
  assign reg_write_address = instruction[11:7];
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    w_alu_op         = C_NOP;
    w_imm            = 12'd0;
    load_operation   = 3'd0;
    store_operation  = 3'd0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    reg_read_enable  = 1'b0;
    reg_write_enable = 1'b0;
    jump             = 1'b0;
    is_jal           = 1'b0;
    is_jalr          = 1'b0;
    case (w_opcode)
      C_OPC_R: begin
        reg_read_enable  = 1'b1;
        reg_write_enable = 1'b1;
        case (w_funct3)
          3'b000:  w_alu_op = w_alt ? C_SUB : C_ADD;
          3'b001:  w_alu_op = C_SLL;
          3'b010:  w_alu_op = C_SLT;
          3'b011:  w_alu_op = C_SLTU;
          3'b100:  w_alu_op = C_XOR;
          3'b101:  w_alu_op = w_alt ? C_SRA : C_SRL;
          3'b110:  w_alu_op = C_OR;
          default: w_alu_op = C_AND;
        endcase
      end
      C_OPC_I: begin
        reg_read_enable  = 1'b1;
        reg_write_enable = 1'b1;
        w_imm            = instruction[31:20];
        case (w_funct3)
          3'b000:  w_alu_op = C_ADDI;
          3'b001:  w_alu_op = C_SLLI;
          3'b010:  w_alu_op = C_SLTI;
          3'b011:  w_alu_op = C_SLTIU;
          3'b100:  w_alu_op = C_XORI;
          3'b101:  w_alu_op = w_alt ? C_SRAI : C_SRLI;
          3'b110:  w_alu_op = C_ORI;
          default: w_alu_op = C_ANDI;
        endcase
      end
      C_OPC_LOAD: begin
        w_alu_op         = C_ADDR;
        w_imm            = instruction[31:20];
        load_operation   = w_funct3;
        mem_read_enable  = 1'b1;
        reg_read_enable  = 1'b1;
        reg_write_enable = 1'b1;
      end
      C_OPC_STORE: begin
        w_alu_op         = C_ADDR;
        w_imm            = {instruction[31:25], instruction[11:7]};
        store_operation  = w_funct3;
        mem_write_enable = 1'b1;
        reg_read_enable  = 1'b1;
      end
      C_OPC_JAL: begin
        jump             = 1'b1;
        is_jal           = 1'b1;
        reg_write_enable = 1'b1;
      end
      C_OPC_JALR: begin
        w_alu_op         = C_ADDR;
        w_imm            = instruction[31:20];
        jump             = 1'b1;
        is_jalr          = 1'b1;
        reg_read_enable  = 1'b1;
        reg_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op     = w_alu_op;
  assign immediate  = w_imm;
  assign w_imm_sext = {{20{w_imm[11]}}, w_imm};

  always_comb begin
    w_res = 32'd0;
    case (w_alu_op)
      C_ADD:   w_res = operand_a + operand_b;
      C_SUB:   w_res = operand_a - operand_b;
      C_SLL:   w_res = operand_a << operand_b[4:0];
      C_SLT:   w_res = {31'd0, $signed(operand_a) < $signed(operand_b)};
      C_SLTU:  w_res = {31'd0, operand_a < operand_b};
      C_XOR:   w_res = operand_a ^ operand_b;
      C_SRL:   w_res = operand_a >> operand_b[4:0];
      C_SRA:   w_res = $unsigned($signed(operand_a) >>> operand_b[4:0]);
      C_OR:    w_res = operand_a | operand_b;
      C_AND:   w_res = operand_a & operand_b;
      C_ADDI:  w_res = operand_a + w_imm_sext;
      C_SLTI:  w_res = {31'd0, $signed(operand_a) < $signed(w_imm_sext)};
      C_SLTIU: w_res = {31'd0, operand_a < w_imm_sext};
      C_XORI:  w_res = operand_a ^ w_imm_sext;
      C_ORI:   w_res = operand_a | w_imm_sext;
      C_ANDI:  w_res = operand_a & w_imm_sext;
      C_SLLI:  w_res = operand_a << w_imm[4:0];
      C_SRLI:  w_res = operand_a >> w_imm[4:0];
      C_SRAI:  w_res = $unsigned($signed(operand_a) >>> w_imm[4:0]);
      C_ADDR:  w_res = operand_a + w_imm_sext;
      default: w_res = 32'd0;
    endcase
  end

  assign alu_result = w_res;
  assign zero       = (w_res == 32'd0);

  logic          r_s1;
  logic          r_s2;
  logic          r_clean;
  logic [CW-1:0] r_cnt;

  // Any return of the synchronized level to the current output restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      if (r_s2 != r_clean) begin
        if (r_cnt == C_CNT_MAX) begin
          r_clean <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign btn_clean = r_clean;

endmodule

`default_nettype wire

// File: tb/tb_rv32_decode_execute.sv
`default_nettype none
// tb_rv32_decode_execute: scoreboarded decode/ALU vectors plus directed debouncer timing.
// Rev 1.0

module tb_rv32_decode_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn;
  logic        btn_clean;
  logic [31:0] instruction, operand_a, operand_b;
  logic [4:0]  alu_op;
  logic [11:0] immediate;
  logic [31:0] imm_j;
  logic [2:0]  load_operation, store_operation;
  logic [4:0]  reg_read_address1, reg_read_address2, reg_write_address;
  logic        mem_read_enable, mem_write_enable, reg_read_enable, reg_write_enable;
  logic        jump, is_jal, is_jalr;
  logic [31:0] alu_result;
  logic        zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  op;
    logic [31:0] res;
    logic [11:0] imm;
    bit          chk_imm;
    logic [6:0]  ctrl;
    logic [2:0]  ld;
    logic [2:0]  st;
    logic [31:0] ij;
    bit          chk_j;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  rv32_decode_execute #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn(btn), .btn_clean(btn_clean),
    .instruction(instruction), .operand_a(operand_a), .operand_b(operand_b),
    .alu_op(alu_op), .immediate(immediate), .imm_j(imm_j),
    .load_operation(load_operation), .store_operation(store_operation),
    .reg_read_address1(reg_read_address1), .reg_read_address2(reg_read_address2),
    .reg_write_address(reg_write_address),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .reg_read_enable(reg_read_enable), .reg_write_enable(reg_write_enable),
    .jump(jump), .is_jal(is_jal), .is_jalr(is_jalr),
    .alu_result(alu_result), .zero(zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {mem_read, mem_write, reg_read, reg_write, jump, is_jal, is_jalr}
  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [31:0] res,
                       input logic [11:0] imm, input bit chk_imm, input logic [6:0] ctrl,
                       input logic [2:0] ld, input logic [2:0] st,
                       input logic [31:0] ij, input bit chk_j);
    exp_t e;
    tick();
    instruction = instr;
    operand_a   = a;
    operand_b   = b;
    e.instr = instr; e.op = op; e.res = res; e.imm = imm; e.chk_imm = chk_imm;
    e.ctrl = ctrl; e.ld = ld; e.st = st; e.ij = ij; e.chk_j = chk_j;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk($sformatf("alu_op %08h", e.instr), 32'(alu_op), 32'(e.op));
      chk($sformatf("result %08h", e.instr), alu_result, e.res);
      chk($sformatf("zero %08h", e.instr), 32'(zero), 32'(e.res == 32'd0));
      chk($sformatf("rs1 %08h", e.instr), 32'(reg_read_address1), 32'(e.instr[19:15]));
      chk($sformatf("rs2 %08h", e.instr), 32'(reg_read_address2), 32'(e.instr[24:20]));
      chk($sformatf("rd %08h", e.instr), 32'(reg_write_address), 32'(e.instr[11:7]));
      chk($sformatf("ctrl %08h", e.instr),
          32'({mem_read_enable, mem_write_enable, reg_read_enable, reg_write_enable,
               jump, is_jal, is_jalr}), 32'(e.ctrl));
      chk($sformatf("load_op %08h", e.instr), 32'(load_operation), 32'(e.ld));
      chk($sformatf("store_op %08h", e.instr), 32'(store_operation), 32'(e.st));
      if (e.chk_imm) chk($sformatf("imm %08h", e.instr), 32'(immediate), 32'(e.imm));
      if (e.chk_j)   chk($sformatf("imm_j %08h", e.instr), imm_j, e.ij);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; btn = 1'b0;
    instruction = 32'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (2) tick();
    chk("rst_btn_clean", 32'(btn_clean), 32'd0);

    //     instr         A             B             op     result        imm     ci ctrl        ld st imm_j        cj
    drive(32'h002081B3, 32'd5,        32'd7,        5'd0,  32'd12,       12'h000, 0, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'h402081B3, 32'd5,        32'd5,        5'd1,  32'd0,        12'h000, 0, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'h402081B3, 32'd5,        32'd7,        5'd1,  32'hFFFFFFFE, 12'h000, 0, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'h40435293, 32'h80000000, 32'd0,        5'd18, 32'hF8000000, 12'h404, 1, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'hFE20AE23, 32'h100,      32'd0,        5'd19, 32'hFC,       12'hFFC, 1, 7'b0110000, 0, 2, 32'd0,       0);
    drive(32'h008000EF, 32'd3,        32'd4,        5'd31, 32'd0,        12'h000, 0, 7'b0001110, 0, 0, 32'd8,       1);
    drive(32'hFFDFF06F, 32'd3,        32'd4,        5'd31, 32'd0,        12'h000, 0, 7'b0001110, 0, 0, 32'hFFFFFFFC, 1);
    drive(32'h0000007F, 32'd9,        32'd9,        5'd31, 32'd0,        12'h000, 1, 7'b0000000, 0, 0, 32'd0,       0);
    drive(32'h00812283, 32'h1000,     32'd0,        5'd19, 32'h1008,     12'h008, 1, 7'b1011000, 2, 0, 32'd0,       0);
    drive(32'hFFC280E7, 32'h2000,     32'd0,        5'd19, 32'h1FFC,     12'hFFC, 1, 7'b0011101, 0, 0, 32'd0,       0);
    drive(32'h0020B1B3, 32'd5,        32'hFFFFFFFF, 5'd4,  32'd1,        12'h000, 0, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'h0020A1B3, 32'd5,        32'hFFFFFFFF, 5'd3,  32'd0,        12'h000, 0, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'hFFF0A193, 32'h80000000, 32'd0,        5'd11, 32'd1,        12'hFFF, 1, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'h002091B3, 32'd1,        32'h23,       5'd2,  32'd8,        12'h000, 0, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'h0020D1B3, 32'h80000000, 32'd4,        5'd6,  32'h08000000, 12'h000, 0, 7'b0011000, 0, 0, 32'd0,       0);
    drive(32'h0F00F193, 32'h12345678, 32'd0,        5'd15, 32'h70,       12'h0F0, 1, 7'b0011000, 0, 0, 32'd0,       0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    // 3-cycle pulse must not propagate
    reset = 1'b0;
    tick();
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("pulse_filtered", 32'(btn_clean), 32'd0);
    end

    // press: first sampling edge k, output rises after edge k+5
    btn = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk($sformatf("press_edge%0d", i), 32'(btn_clean), 32'(i == 5));
    end

    // asynchronous reset clears the level between edges, then the count restarts
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'(btn_clean), 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk($sformatf("restart_edge%0d", i), 32'(btn_clean), 32'(i == 5));
    end

    btn = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk($sformatf("release_edge%0d", i), 32'(btn_clean), 32'(i != 5));
    end

    // reset in the middle of a count
    btn = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1 chk("midcount_reset", 32'(btn_clean), 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk($sformatf("midcount_edge%0d", i), 32'(btn_clean), 32'(i == 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
